hex_display_checker: RTL
========================

# hex_display_checker

Receive-side monitor for the two-digit seven-segment bus driven by the counter's display stage. It samples the active-low segment patterns of HEX1/HEX0 on a strobe and decodes them back to an 8-bit value. It flags patterns outside the 16-glyph set and checks that successive values follow legal counter behaviour (hold, +1 with wrap, or clear). It sits beside the counter as a self-check and bench observer, and drives no display itself.

## Interface
- LOCK_COUNT, 2: consecutive legal samples required before sequence checking is armed (range 1-15).
- clock  input  1  system clock, rising edge.
- clear_b  input  1  asynchronous active-low reset.
- sample  input  1  capture strobe; every cycle it is high is one sample.
- hex1_in  input  7  upper-digit segments, bit 0 = seg a … bit 6 = seg g, 0 = lit.
- hex0_in  input  7  lower-digit segments, same encoding.
- value  output  8  last legally decoded value, {hex1 nibble, hex0 nibble}.
- valid  output  1  one-cycle pulse: value updated by a legal sample.
- code_err  output  1  one-cycle pulse: a digit pattern was not in the glyph set.
- seq_err  output  1  one-cycle pulse: legal value broke the sequence rule while locked.
- locked  output  1  sequence checking armed.
- err_count  output  8  saturating count of code_err plus seq_err events.

## Operation
- The glyph set is given as HEX[6:0] in hex, for digits 0-F in order: 40, 79, 24, 30, 19, 12, 02, 78, 00, 18, 08, 03, 46, 21, 06, 0E.
  - 9 is 18, drawn without seg d.
  - Every other 7-bit pattern is illegal.
- Both digits are decoded in parallel. A sample is legal only if both digits are legal.
- Illegal sample:
  - code_err pulses.
  - value is held.
  - State goes to UNLOCKED and the good-count is zeroed.
  - err_count increments.
- Legal sample: value takes the decoded byte and valid pulses. Then, by state:
  - UNLOCKED:
    - If new == prev, new == prev+1 (mod 256) or new == 0, the good-count increments; otherwise the good-count is set to 1.
    - The first legal sample after reset or after a code error always sets the good-count to 1.
    - When the good-count reaches LOCK_COUNT, go to LOCKED and assert locked.
  - LOCKED:
    - new == prev (counter disabled), new == prev+1 mod 256 (FF→00 is legal), or new == 00 (clear) is accepted silently.
    - Anything else pulses seq_err and increments err_count.
    - State stays LOCKED, and the reference for the next comparison becomes the new value.
- err_count saturates at FF and never wraps.
- If code_err and seq_err would coincide, code_err takes priority and seq_err is not evaluated. err_count increments once per sample.
- clear_b low at any time, including mid-sample, immediately forces the reset state below. The sample in flight is discarded.

## Timing
- Reset values:
  - value = 00
  - valid = 0
  - code_err = 0
  - seq_err = 0
  - locked = 0
  - err_count = 00
  - state = UNLOCKED
  - good-count = 0
  - no previous-value reference
- Sample latency: inputs are captured on the rising edge where sample = 1 (edge t). valid, code_err, seq_err, value, locked and err_count reflect that sample after edge t+1. The latency is fixed at 1 cycle.
- The design is fully pipelined: back-to-back samples on consecutive cycles are each evaluated, with no gaps and no dropped samples.
- With sample = 0, all pulse outputs are 0 on the following cycle. The other outputs hold.
- locked rises in the same cycle as the valid of the LOCK_COUNT-th good sample. It falls in the same cycle as the code_err pulse.
- All outputs are registered and no output is combinational from the inputs.

## Test plan
- Reset then count: release clear_b, then sample patterns 40/40, 40/79, 40/24 (values 00, 01, 02).
  - Required: valid on each sample, value 00, 01, 02, locked = 1 after the second sample, no errors.
- Wrap and hold: locked at value FE, then sample FF, FF, 00.
  - Required: value FF, FF, 00, seq_err stays 0, err_count unchanged.
- Illegal glyph: sample hex0_in = 7F (blank) while locked at 05.
  - Required: code_err pulse, value stays 05, locked = 0, err_count +1.
  - Then two legal samples 06, 07 relock with no seq_err.
- Sequence break: locked at 10, then sample 13.
  - Required: seq_err pulse, value = 13, err_count +1.
  - A following sample of 14 is accepted silently.
- Saturation and priority: inject 300 illegal samples.
  - Required: err_count stops at FF.
  - A sample that is both an illegal glyph and out of sequence counts once and shows only code_err.
- Async reset mid-stream: assert clear_b for half a cycle while sample = 1.
  - Required: all outputs at reset values before the next edge, and no valid for the dropped sample.

Source files
------------

// File: rtl/hex_display_checker.sv
// Receive-side monitor for a two-digit active-low seven-segment bus: decodes sampled
// glyphs back to a byte, flags illegal patterns and checks hold / +1 / clear sequencing.
module hex_display_checker #(
    parameter int LOCK_COUNT = 2
) (
    input  logic       clock,
    input  logic       clear_b,
    input  logic       sample,
    input  logic [6:0] hex1_in,
    input  logic [6:0] hex0_in,
    output logic [7:0] value,
    output logic       valid,
    output logic       code_err,
    output logic       seq_err,
    output logic       locked,
    output logic [7:0] err_count
);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    localparam logic [3:0] LOCK_LIMIT = 4'(LOCK_COUNT);

    // {legal, nibble}; anything outside the 16-glyph set decodes as illegal.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h40:   res = 5'h10;
            7'h79:   res = 5'h11;
            7'h24:   res = 5'h12;
            7'h30:   res = 5'h13;
            7'h19:   res = 5'h14;
            7'h12:   res = 5'h15;
            7'h02:   res = 5'h16;
            7'h78:   res = 5'h17;
            7'h00:   res = 5'h18;
            7'h18:   res = 5'h19;
            7'h08:   res = 5'h1A;
            7'h03:   res = 5'h1B;
            7'h46:   res = 5'h1C;
            7'h21:   res = 5'h1D;
            7'h06:   res = 5'h1E;
            7'h0E:   res = 5'h1F;
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    // Capture stage: the sample taken on edge t is evaluated on edge t+1.
    logic       smp_reg;
    logic [6:0] seg_reg [2];
    logic [4:0] dec     [2];

    state_t     state_reg;
    logic [3:0] good_reg;
    logic       have_prev_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_digit
            assign dec[gi] = decode_glyph(seg_reg[gi]);
        end
    endgenerate

    logic       legal;
    logic [7:0] new_value;
    logic       seq_ok;
    logic [3:0] good_next;
    logic [7:0] err_count_next;

    always_comb begin
        legal          = dec[1][4] & dec[0][4];
        new_value      = {dec[1][3:0], dec[0][3:0]};
        seq_ok         = have_prev_reg &&
                         ((new_value == value) || (new_value == value + 8'd1) || (new_value == 8'd0));
        good_next      = 4'd1;
        if (seq_ok) begin
            good_next = (good_reg == 4'hF) ? 4'hF : good_reg + 4'd1;
        end
        err_count_next = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;
    end

    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            smp_reg       <= 1'b0;
            seg_reg[1]    <= 7'h7F;
            seg_reg[0]    <= 7'h7F;
            state_reg     <= UNLOCKED;
            good_reg      <= 4'd0;
            have_prev_reg <= 1'b0;
            value         <= 8'h00;
            valid         <= 1'b0;
            code_err      <= 1'b0;
            seq_err       <= 1'b0;
            locked        <= 1'b0;
            err_count     <= 8'h00;
        end else begin
            smp_reg    <= sample;
            seg_reg[1] <= hex1_in;
            seg_reg[0] <= hex0_in;
            valid      <= 1'b0;
            code_err   <= 1'b0;
            seq_err    <= 1'b0;
            if (smp_reg) begin
                if (!legal) begin
                    // Code errors win: sequencing is not evaluated and the reference is dropped.
                    code_err      <= 1'b1;
                    state_reg     <= UNLOCKED;
                    locked        <= 1'b0;
                    good_reg      <= 4'd0;
                    have_prev_reg <= 1'b0;
                    err_count     <= err_count_next;
                end else begin
                    value         <= new_value;
                    valid         <= 1'b1;
                    have_prev_reg <= 1'b1;
                    if (state_reg == UNLOCKED) begin
                        good_reg <= good_next;
                        if (good_next >= LOCK_LIMIT) begin
                            state_reg <= LOCKED;
                            locked    <= 1'b1;
                        end
                    end else if (!seq_ok) begin
                        seq_err   <= 1'b1;
                        err_count <= err_count_next;
                    end
                end
            end
        end
    end

endmodule
